noc_host_packetizer: RTL

NOC_HOST_PACKETIZER -- requirements
Module: noc_host_packetizer

---
 rtl/noc_host_packetizer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/noc_host_packetizer.sv
// Host-side NoC packetizer: turns a command (destination + length) and a
// stream of payload words into head/body/tail flits for one mesh ingress port.
module noc_host_packetizer #(
    parameter int FLIT_W = 64,
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_dest_row,
    input  logic [3:0]        cmd_dest_col,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [FLIT_W-3:0] data_word,
    output logic [FLIT_W-1:0] flit_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              err_dest,
    output logic [15:0]       pkt_count
);

    // Zero padding below the length field of a head flit.
    localparam int PAD_W = FLIT_W - 2 - 8 - LEN_W;

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    localparam logic [4:0] ROWS_L = 5'(ROWS);
    localparam logic [4:0] COLS_L = 5'(COLS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEAD,
        S_BODY,
        S_DRAIN
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [FLIT_W-1:0]   r_flit;
    logic                r_valid;
    logic                r_err;
    logic [15:0]         r_pkt_count;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_remaining;

    logic                w_dest_ok;
    logic                w_cmd_fire;
    logic                w_out_fire;
    logic                w_data_fire;
    logic                w_last_data;
    logic [1:0]          w_head_type;
    logic [FLIT_W-1:0]   w_head_flit;

    assign w_dest_ok   = ({1'b0, cmd_dest_row} < ROWS_L) && ({1'b0, cmd_dest_col} < COLS_L);
    assign w_cmd_fire  = cmd_valid & cmd_ready;
    assign w_out_fire  = r_valid & ready_in;
    assign w_data_fire = data_valid & data_ready;
    assign w_last_data = (r_remaining == LEN_W'(1));
    // A zero-length packet is a lone head that also closes the packet.
    assign w_head_type = (cmd_len == '0) ? T_SINGLE : T_HEAD;
    assign w_head_flit = {w_head_type, cmd_dest_row, cmd_dest_col, cmd_len, {PAD_W{1'b0}}};

    assign flit_out  = r_flit;
    assign valid_out = r_valid;
    assign err_dest  = r_err;
    assign pkt_count = r_pkt_count;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake-ready decode; both readies are masked by reset.
    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        data_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = ~rst;
                if (w_cmd_fire && w_dest_ok) begin
                    w_state_next = S_HEAD;
                end
            end
            S_HEAD: begin
                if (w_out_fire) begin
                    w_state_next = (r_len == '0) ? S_IDLE : S_BODY;
                end
            end
            S_BODY: begin
                // A new payload word may only enter when the output slot frees up.
                data_ready = ~rst & (~r_valid | ready_in);
                if (w_data_fire && w_last_data) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_out_fire) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output flit register, length bookkeeping, error pulse and packet counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flit      <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_pkt_count <= '0;
            r_len       <= '0;
            r_remaining <= '0;
        end else begin
            r_err <= w_cmd_fire & ~w_dest_ok;
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire && w_dest_ok) begin
                        r_len   <= cmd_len;
                        r_flit  <= w_head_flit;
                        r_valid <= 1'b1;
                    end
                end
                S_HEAD: begin
                    if (w_out_fire) begin
                        r_valid <= 1'b0;
                        if (r_len == '0) begin
                            r_pkt_count <= r_pkt_count + 16'd1;
                        end else begin
                            r_remaining <= r_len;
                        end
                    end
                end
                S_BODY: begin
                    if (w_data_fire) begin
                        r_flit      <= {(w_last_data ? T_TAIL : T_BODY), data_word};
                        r_valid     <= 1'b1;
                        r_remaining <= r_remaining - LEN_W'(1);
                    end else if (w_out_fire) begin
                        r_valid <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (w_out_fire) begin
                        r_valid     <= 1'b0;
                        r_pkt_count <= r_pkt_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
